mem_stage_ctrl: RTL and testbench
=================================

# mem_stage_ctrl

Memory-stage access controller: the responder for the MemRead/MemWrite requests that the M control register hands to the memory stage. It turns each request into a single transaction on a multi-cycle data-memory port and holds the whole pipeline with `stall` until that transaction completes. A one-entry read buffer keeps the last read word, so a read to the same address completes without a stall. It sits between the M-stage control/ALU outputs and main data memory; `stall` drives the `wen` of every upstream pipeline register.

## Interface
- ADDR_W, 16, address width
- DATA_W, 16, data width
- TIMEOUT, 255, max WAIT cycles before abort (≥1)

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- MemRead  in  1  read request from M control register
- MemWrite  in  1  write request from M control register
- addr  in  ADDR_W  access address (ALU result)
- wdata  in  DATA_W  store data
- rdata  out  DATA_W  load result = buffer data
- stall  out  1  hold upstream pipeline registers (combinational)
- err  out  1  sticky: illegal request or timeout
- mem_en  out  1  one-cycle request strobe to memory (registered)
- mem_wr  out  1  1=write, valid with mem_en (registered)
- mem_addr  out  ADDR_W  request address (registered)
- mem_wdata  out  DATA_W  request write data (registered)
- mem_ack  in  1  memory completion; carries mem_rdata for reads
- mem_rdata  in  DATA_W  read data, valid with mem_ack

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- A request is present when MemRead or MemWrite is high. If both are high, the access is treated as a write and `err` is set.
- Hit: the request is a read, buf_valid is 1 and addr == buf_addr.
- IDLE:
  - No request → stall=0.
  - Hit → stall=0, rdata=buf_data, state stays IDLE.
  - Miss or any write → stall=1; capture addr, wdata and wr into the request registers; next state REQ.
- REQ:
  - stall=1, mem_en=1 for exactly this cycle; next state WAIT; clear the timeout counter.
- WAIT:
  - stall=1 while waiting.
  - On mem_ack, a read loads buf_addr/buf_data and sets buf_valid. A write whose address equals buf_addr (with buf_valid=1) updates buf_data with the write data (write-through, keeps the buffer coherent). Next state DONE.
  - On counter == TIMEOUT with no ack: set err, clear buf_valid, next state DONE.
- DONE:
  - stall=0 for one cycle so the pipeline advances; next state IDLE.
  - The stage samples rdata in this cycle.
- mem_ack is ignored outside WAIT, including a late ack arriving after reset.
- The timeout counter saturates and uses $clog2(TIMEOUT+1) bits.
- err clears only on reset.

## Timing
- Reset values: all outputs 0, state IDLE, buf_valid 0, counter 0. Reset is asynchronous: asserting it mid-transaction aborts the transaction immediately.
- Read hit: 0 stall cycles.
- Miss or write, with mem_ack arriving L cycles after mem_en (L ≥ 1): stall is high for L+2 cycles (IDLE-detect, REQ, then L WAIT cycles); DONE is the cycle after the ack.
- Request inputs are sampled only in IDLE. They are held stable while stall=1, guaranteed by the upstream registers.
- mem_* outputs are registered and hold their values from REQ until the next REQ.
- Back-to-back accesses: DONE→IDLE costs no extra cycle, and a new request is evaluated in the IDLE cycle that follows DONE.

## Structure
- Shared package wisc_pkg: the state enum type, ADDR_W/DATA_W defaults and the TIMEOUT default.
- One sub-module: mem_rd_buf, the one-entry address/data/valid buffer with hit compare, load and write-update ports.
- The FSM, request registers and counter live in the top module.

## Test plan
- Read miss at addr 0x0040, memory returns 0xBEEF with L=4 → mem_en pulse one cycle after detect; stall high for 6 cycles; DONE rdata=0xBEEF; stall=0.
- Immediate repeat read of 0x0040 → no stall, no mem_en, rdata=0xBEEF.
- Write 0x1234 to 0x0040, then read 0x0040 → write: mem_wr=1, 6 stall cycles. Read is then a hit returning 0x1234.
- MemRead and MemWrite both high → handled as a write, err=1 and stays 1.
- TIMEOUT=8, no mem_ack → stall for 10 cycles, err=1, buf_valid=0. The next read to the same address misses.
- rst low during WAIT, followed by a stray mem_ack after release → all outputs 0, state IDLE, the ack is ignored, buf_valid=0.

Source files
------------

// File: rtl/wisc_pkg.sv
// Shared types and default widths for the memory-stage access controller.
// Holds the controller FSM encoding and the default address/data/timeout values.
package wisc_pkg;

  localparam int ADDR_W_DEF  = 16;
  localparam int DATA_W_DEF  = 16;
  localparam int TIMEOUT_DEF = 255;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } mem_state_e;

endpackage

// File: rtl/mem_rd_buf.sv
// One-entry read buffer: remembers the last word read from data memory so a
// repeat load of the same address can complete without a memory transaction.
module mem_rd_buf #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] lookup_addr,
  output logic              hit,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              inv,
  output logic [DATA_W-1:0] buf_data
);

  logic              buf_valid;
  logic [ADDR_W-1:0] buf_addr;

  assign hit = buf_valid && (lookup_addr == buf_addr);

  // Data is reset as well because it drives the rdata output directly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_valid <= 1'b0;
      buf_addr  <= '0;
      buf_data  <= '0;
    end else if (inv) begin
      buf_valid <= 1'b0;
    end else if (ld_en) begin
      buf_valid <= 1'b1;
      buf_addr  <= ld_addr;
      buf_data  <= ld_data;
    end else if (wr_en && buf_valid && (wr_addr == buf_addr)) begin
      // Write-through keeps a buffered copy coherent with memory.
      buf_data  <= wr_data;
    end
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory-stage access controller: turns MemRead/MemWrite into a single
// multi-cycle memory transaction and holds the pipeline until it completes.
module mem_stage_ctrl
  import wisc_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              stall,
  output logic              err,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int               CNT_W   = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  mem_state_e       state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             buf_hit;
  logic             rd_hit;
  logic             start;
  logic             ack_ld;
  logic             ack_wr;
  logic             tmo;

  // A simultaneous read+write request is treated as a write, never as a hit.
  assign rd_hit = MemRead && !MemWrite && buf_hit;

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    start     = 1'b0;
    ack_ld    = 1'b0;
    ack_wr    = 1'b0;
    tmo       = 1'b0;
    case (state)
      IDLE: begin
        if ((MemRead || MemWrite) && !rd_hit) begin
          stall     = 1'b1;
          start     = 1'b1;
          state_nxt = REQ;
        end
      end
      REQ: begin
        stall     = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        stall = 1'b1;
        if (mem_ack) begin
          ack_wr    = mem_wr;
          ack_ld    = !mem_wr;
          state_nxt = DONE;
        end else if (cnt == CNT_MAX) begin
          tmo       = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Request registers double as the memory port: loaded at detect, so they
  // are valid in REQ and hold until the next request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_en    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_en <= start;
      if (start) begin
        mem_wr    <= MemWrite;
        mem_addr  <= addr;
        mem_wdata <= wdata;
      end
    end
  end

  // Counter is zero in REQ and counts cycles since mem_en, so it equals the
  // ack latency when the ack arrives.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= '0;
    end else if (((state == REQ) || (state == WAIT)) && (cnt != CNT_MAX)) begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                  err <= 1'b0;
    else if ((start && MemRead && MemWrite) || tmo) err <= 1'b1;
  end

  mem_rd_buf #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_rd_buf (
    .clk         (clk),
    .rst         (rst),
    .lookup_addr (addr),
    .hit         (buf_hit),
    .ld_en       (ack_ld),
    .ld_addr     (mem_addr),
    .ld_data     (mem_rdata),
    .wr_en       (ack_wr),
    .wr_addr     (mem_addr),
    .wr_data     (mem_wdata),
    .inv         (tmo),
    .buf_data    (rdata)
  );

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl with a cycle-driven memory responder.
module tb_mem_stage_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic [15:0] addr = '0;
  logic [15:0] wdata = '0;
  logic [15:0] rdata;
  logic        stall;
  logic        err;
  logic        mem_en;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_rdata = '0;

  int checks = 0;
  int errors = 0;

  mem_stage_ctrl #(
    .ADDR_W  (16),
    .DATA_W  (16),
    .TIMEOUT (8)
  ) dut (
    .clk       (clk),
    .rst       (rst_n),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .stall     (stall),
    .err       (err),
    .mem_en    (mem_en),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    MemRead = 1'b0;
    MemWrite = 1'b0;
    mem_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // One access from detect to the first non-stalled cycle. lat < 0 means the
  // memory never acknowledges.
  task automatic run_access(input logic rd, input logic wr, input logic [15:0] a,
                            input logic [15:0] wd, input int lat, input logic [15:0] mrd,
                            output int stall_cnt, output int en_k, output int en_cnt,
                            output logic [15:0] a_seen, output logic wr_seen,
                            output logic [15:0] wd_seen, output logic [15:0] rd_done);
    logic done;
    done = 1'b0;
    stall_cnt = 0; en_k = -1; en_cnt = 0;
    a_seen = '0; wr_seen = 1'b0; wd_seen = '0; rd_done = '0;
    @(posedge clk); #1;
    MemRead = rd; MemWrite = wr; addr = a; wdata = wd;
    for (int k = 0; k < 40; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
      end
      mem_ack   = (lat >= 0) && (en_k >= 0) && (k == en_k + lat);
      mem_rdata = mem_ack ? mrd : 16'h0000;
      @(negedge clk);
      if (mem_en) begin
        en_cnt++;
        if (en_k < 0) en_k = k;
        a_seen = mem_addr; wr_seen = mem_wr; wd_seen = mem_wdata;
      end
      if (stall) stall_cnt++;
      else begin
        rd_done = rdata;
        done = 1'b1;
        break;
      end
    end
    if (!done) check_eq("access_budget", 32'd0, 32'd1);
    @(posedge clk); #1;
    MemRead = 1'b0; MemWrite = 1'b0; mem_ack = 1'b0;
  endtask

  initial begin
    int sc, ek, ec;
    logic [15:0] ma, mwd, rdd;
    logic mw;

    do_reset();
    @(negedge clk);
    check_eq("rst_rdata", rdata, 16'h0);
    check_eq("rst_stall", stall, 1'b0);
    check_eq("rst_err", err, 1'b0);
    check_eq("rst_mem_en", mem_en, 1'b0);
    check_eq("rst_mem_wr", mem_wr, 1'b0);
    check_eq("rst_mem_addr", mem_addr, 16'h0);
    check_eq("rst_mem_wdata", mem_wdata, 16'h0);

    // Read miss, L=4
    run_access(1'b1, 1'b0, 16'h0040, 16'h0, 4, 16'hBEEF, sc, ek, ec, ma, mw, mwd, rdd);
    check_eq("miss_stall_cycles", sc, 6);
    check_eq("miss_en_cycle", ek, 1);
    check_eq("miss_en_count", ec, 1);
    check_eq("miss_mem_addr", ma, 16'h0040);
    check_eq("miss_mem_wr", mw, 1'b0);
    check_eq("miss_rdata", rdd, 16'hBEEF);
    check_eq("miss_err", err, 1'b0);

    // Repeat read hits
    run_access(1'b1, 1'b0, 16'h0040, 16'h0, 4, 16'h0000, sc, ek, ec, ma, mw, mwd, rdd);
    check_eq("hit_stall_cycles", sc, 0);
    check_eq("hit_en_count", ec, 0);
    check_eq("hit_rdata", rdd, 16'hBEEF);

    // Write-through to buffered address
    run_access(1'b0, 1'b1, 16'h0040, 16'h1234, 4, 16'h0000, sc, ek, ec, ma, mw, mwd, rdd);
    check_eq("wr_stall_cycles", sc, 6);
    check_eq("wr_en_count", ec, 1);
    check_eq("wr_mem_wr", mw, 1'b1);
    check_eq("wr_mem_wdata", mwd, 16'h1234);
    run_access(1'b1, 1'b0, 16'h0040, 16'h0, 4, 16'h0000, sc, ek, ec, ma, mw, mwd, rdd);
    check_eq("wr_hit_stall", sc, 0);
    check_eq("wr_hit_rdata", rdd, 16'h1234);
    check_eq("mem_addr_hold", mem_addr, 16'h0040);
    check_eq("mem_wr_hold", mem_wr, 1'b1);

    // Both requests high: write plus err, L=2
    run_access(1'b1, 1'b1, 16'h0080, 16'h5555, 2, 16'h0000, sc, ek, ec, ma, mw, mwd, rdd);
    check_eq("both_stall_cycles", sc, 4);
    check_eq("both_mem_wr", mw, 1'b1);
    check_eq("both_mem_addr", ma, 16'h0080);
    check_eq("both_err", err, 1'b1);
    run_access(1'b1, 1'b0, 16'h0040, 16'h0, 4, 16'h0000, sc, ek, ec, ma, mw, mwd, rdd);
    check_eq("both_buf_intact_stall", sc, 0);
    check_eq("both_buf_intact_rdata", rdd, 16'h1234);
    check_eq("err_sticky", err, 1'b1);

    // Timeout with TIMEOUT=8
    do_reset();
    @(negedge clk);
    check_eq("rst2_err", err, 1'b0);
    run_access(1'b1, 1'b0, 16'h0100, 16'h0, 1, 16'hA5A5, sc, ek, ec, ma, mw, mwd, rdd);
    check_eq("l1_stall_cycles", sc, 3);
    check_eq("l1_rdata", rdd, 16'hA5A5);
    run_access(1'b0, 1'b1, 16'h0100, 16'h0F0F, -1, 16'h0000, sc, ek, ec, ma, mw, mwd, rdd);
    check_eq("tmo_stall_cycles", sc, 10);
    check_eq("tmo_en_count", ec, 1);
    check_eq("tmo_err", err, 1'b1);
    run_access(1'b1, 1'b0, 16'h0100, 16'h0, 3, 16'h7777, sc, ek, ec, ma, mw, mwd, rdd);
    check_eq("tmo_next_miss_stall", sc, 5);
    check_eq("tmo_next_rdata", rdd, 16'h7777);

    // Asynchronous reset in WAIT, then a stray ack
    @(posedge clk); #1;
    MemRead = 1'b1; addr = 16'h0200;
    repeat (4) @(posedge clk);
    #2;
    check_eq("pre_rst_stall", stall, 1'b1);
    rst_n = 1'b0; MemRead = 1'b0;
    #1;
    check_eq("arst_stall", stall, 1'b0);
    check_eq("arst_rdata", rdata, 16'h0);
    check_eq("arst_err", err, 1'b0);
    check_eq("arst_mem_en", mem_en, 1'b0);
    check_eq("arst_mem_addr", mem_addr, 16'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    mem_ack = 1'b1; mem_rdata = 16'hDEAD;
    @(negedge clk);
    check_eq("stray_stall", stall, 1'b0);
    check_eq("stray_mem_en", mem_en, 1'b0);
    @(posedge clk); #1 mem_ack = 1'b0; mem_rdata = 16'h0;
    @(negedge clk);
    check_eq("stray_rdata", rdata, 16'h0);
    check_eq("stray_stall2", stall, 1'b0);
    run_access(1'b1, 1'b0, 16'h0200, 16'h0, 2, 16'h1111, sc, ek, ec, ma, mw, mwd, rdd);
    check_eq("post_rst_miss_stall", sc, 4);
    check_eq("post_rst_rdata", rdd, 16'h1111);
    check_eq("post_rst_err", err, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
